// File: rtl/lsu_ctrl.sv
// Load/store unit between the memory-stage request and word-addressed dmem.
// Sub-word stores are read-modify-write because dmem has a word-wide enable.
module lsu_ctrl #(
  parameter int unsigned MEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WRITE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        is_sw;
  logic        is_sub_store;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    unique case (1'b1)
      (req_funct3 == 3'b011),
      (req_funct3[2:1] == 2'b11):
        illegal = 1'b1;
      (req_funct3[2] && req_we):
        illegal = 1'b1;
      (req_funct3[1:0] == 2'b01):
        misaligned = req_addr[0];
      (req_funct3 == 3'b010):
        misaligned = |req_addr[1:0];
      default: ;
    endcase
    out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_SIZE);
    req_err      = illegal || misaligned || out_of_range;
  end

  assign is_sw        = we_q && (funct3_q == 3'b010);
  assign is_sub_store = we_q && (funct3_q[2:1] == 2'b00);
  assign byte_sh      = {addr_q[1:0], 3'b000};
  assign half_sh      = {addr_q[1], 4'b0000};
  assign ld_byte      = 8'(mem_rd >> byte_sh);
  assign ld_half      = 16'(mem_rd >> half_sh);

  always_comb begin
    ld_ext = 32'h0;
    unique case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = mem_rd;
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = 32'h0;
    endcase
  end

  always_comb begin
    if (funct3_q[0]) begin
      st_merge = (mem_rd & ~(32'h0000_FFFF << half_sh))
               | ({16'h0, wdata_q[15:0]} << half_sh);
    end else begin
      st_merge = (mem_rd & ~(32'h0000_00FF << byte_sh))
               | ({24'h0, wdata_q[7:0]} << byte_sh);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = req_err ? RESP : EXEC;
      EXEC:  state_d = is_sub_store ? WRITE : RESP;
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    if (accept) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      err_d    = req_err;
      rdata_d  = 32'h0;
    end
    if (state_q == EXEC) begin
      if (!we_q) rdata_d = ld_ext;
      if (is_sub_store) merge_d = st_merge;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
    end else begin
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
    end
  end

  assign mem_a = {2'b00, addr_q[31:2]};

  // Outputs decode from state_q only, so reset kills mem_we asynchronously.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    mem_we    = 1'b0;
    mem_wd    = 32'h0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      EXEC: begin
        if (is_sw) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        mem_wd = merge_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
